// File: rtl/usart_pkg.sv
// Shared types and constants for the USART transmit arbiter.
package usart_pkg;

  localparam int USART_BYTE_W      = 8;
  // Width of the optional grant watchdog counter.
  localparam int USART_STALL_CNT_W = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } usart_arb_state_t;

endpackage

// File: rtl/usart_tx_arbiter_rr_picker.sv
// Rotating-priority encoder: picks the first set request bit searching
// upward from last_id+1 (wrapping), so the previous winner ranks last.
module rr_picker
  import usart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic               found,
  output logic [ID_W-1:0]    next_id
);

  // Walk offsets 1..NUM_REQ; the first hit wins.
  always_comb begin
    int idx;
    found   = 1'b0;
    next_id = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_id) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found   = 1'b1;
        next_id = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/usart_tx_arbiter.sv
// Round-robin arbiter sharing one USART transmitter among NUM_REQ byte
// streams. A winner keeps the transmitter until its 'last' byte is accepted.
// Optional grant watchdog: define USART_ARB_TIMEOUT_EN.
module usart_tx_arbiter
  import usart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           comm_clock,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*USART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [USART_BYTE_W-1:0]        tx_data,
  output logic                           tx_valid,
  input  logic                           tx_ready,
  output logic [ID_W-1:0]                grant_id,
  output logic                           busy
`ifdef USART_ARB_TIMEOUT_EN
  ,
  output logic                           timeout_pulse
`endif
);

  usart_arb_state_t state;
  logic [ID_W-1:0]  last_id;
  logic [ID_W-1:0]  next_id;
  logic             found;
  logic             in_grant;
  logic             hs;
  logic             pkt_end;
  logic             revoke;

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req     (req_valid),
    .last_id (last_id),
    .found   (found),
    .next_id (next_id)
  );

  assign in_grant = (state == GRANT);
  assign busy     = in_grant;

  // Combinational pass-through from the owner to the transmitter.
  always_comb begin
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    if (in_grant) begin
      tx_valid            = req_valid[grant_id];
      tx_data             = req_data[int'(grant_id)*USART_BYTE_W +: USART_BYTE_W];
      req_ready[grant_id] = tx_ready;
    end
  end

  assign hs      = tx_valid & tx_ready;
  assign pkt_end = hs & req_last[grant_id];

`ifdef USART_ARB_TIMEOUT_EN
  logic [USART_STALL_CNT_W-1:0] stall_cnt;

  // Revoke when the owner has made no progress for TIMEOUT_CYCLES cycles.
  assign revoke        = in_grant & ~hs &
                         (stall_cnt == USART_STALL_CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_pulse = revoke;

  // Stall counter: held at zero in IDLE so it starts clean on every grant.
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n)             stall_cnt <= '0;
    else if (!in_grant || hs) stall_cnt <= '0;
    else                      stall_cnt <= stall_cnt + 1'b1;
  end
`else
  assign revoke = 1'b0;
`endif

  // Arbitration FSM: pick in IDLE, hold the grant until last byte or revoke.
  always_ff @(posedge comm_clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant_id <= '0;
      last_id  <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= next_id;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (pkt_end || revoke) begin
            last_id <= grant_id;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Scoreboard bench for usart_tx_arbiter. Requesters draw bytes from per-port
// queues; a packet-level round-robin model predicts which byte crosses the
// link in which cycle, and a negedge monitor compares the DUT against it.
module tb_usart_tx_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int T   = 8;

  logic           comm_clock = 1'b0;
  logic           reset_n    = 1'b1;
  logic [N-1:0]   req_valid  = '0;
  logic [N*8-1:0] req_data   = '0;
  logic [N-1:0]   req_last   = '0;
  logic           tx_ready   = 1'b0;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic [IDW-1:0] grant_id;
  logic           busy;
`ifdef USART_ARB_TIMEOUT_EN
  logic           timeout_pulse;
`endif

  usart_tx_arbiter #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT_CYCLES(T)) dut (
    .comm_clock (comm_clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef USART_ARB_TIMEOUT_EN
    ,
    .timeout_pulse (timeout_pulse)
`endif
  );

  always #5 comm_clock = ~comm_clock;

  typedef struct {
    int         cyc;
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [8:0] rq [N][$];     // {last, data} per requester
  bit [N-1:0] mute = '0;
  int         grants[$];
  int errors = 0, nchecks = 0;
  int cyc = 0;
  int vmode = 0, rmode = 0;  // valid: 0 dense/1 random; ready: 0 one/1 random/2 toggle
  bit chk_en = 0, prev_busy = 0;
  // model state
  int owner = -1, last = N - 1, stall = 0;
  bit exp_busy = 0, exp_pulse = 0;
  int exp_gid = 0;
  int pulse_cnt = 0, pulse_cyc = 0, hs1_cyc = 0;

  task automatic chk(string nm, int act, int expv);
    nchecks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Packet-level reference: who owns the link and which byte moves this cycle.
  task automatic model_eval();
    int nxt;
    bit lastf;
    exp_busy  = (owner >= 0);
    exp_gid   = (owner >= 0) ? owner : 0;
    exp_pulse = 0;
    if (owner < 0) begin
      nxt = -1;
      for (int k = 1; k <= N; k++)
        if (nxt < 0 && req_valid[(last + k) % N]) nxt = (last + k) % N;
      if (nxt >= 0) begin owner = nxt; stall = 0; end
    end else if (req_valid[owner] && tx_ready) begin
      exp_q.push_back('{cyc, owner, rq[owner][0][7:0]});
      lastf = rq[owner][0][8];
      void'(rq[owner].pop_front());
      stall = 0;
      if (lastf) begin last = owner; owner = -1; end
    end else begin
`ifdef USART_ARB_TIMEOUT_EN
      if (stall == T - 1) begin exp_pulse = 1; last = owner; owner = -1; end
      else stall++;
`endif
    end
  endtask

  task automatic step();
    @(posedge comm_clock); #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      logic v;
      v = (rq[i].size() != 0) && !mute[i] && (vmode == 0 || $urandom_range(3) != 0);
      req_valid[i]        = v;
      req_data[i*8 +: 8]  = v ? rq[i][0][7:0] : 8'h00;
      req_last[i]         = v ? rq[i][0][8] : 1'b0;
    end
    tx_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(1)) : 1'(cyc % 2);
    model_eval();
  endtask

  task automatic load_pkt(int r, int len, bit rnd, logic [7:0] b0);
    for (int k = 0; k < len; k++) begin
      logic [7:0] d;
      d = rnd ? 8'($urandom) : b0 + 8'(k);
      rq[r].push_back({(k == len - 1), d});
    end
  endtask

  function automatic bit pending();
    pending = 0;
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) pending = 1;
  endfunction

  task automatic drain();
    int n = 0;
    while ((pending() || owner >= 0) && n < 3000) begin step(); n++; end
    if (n >= 3000) begin
      nchecks++; errors++;
      $display("FAIL drain_timeout: got %0d cycles expected < 3000", n);
    end
    step(); step();
    chk("exp_q_empty", exp_q.size(), 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    logic [8:0] b;
    chk_en  = 0;
    reset_n = 1'b0;
    exp_q.delete();
    if (owner >= 0) begin
      b = 9'h100;
      if (rq[owner].size() != 0)
        do b = rq[owner].pop_front(); while (!b[8] && rq[owner].size() != 0);
    end
    req_valid = '0; req_last = '0; req_data = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_id", grant_id, 0);
`ifdef USART_ARB_TIMEOUT_EN
    chk("rst_timeout_pulse", timeout_pulse, 0);
`endif
    repeat (2) @(posedge comm_clock);
    #2 reset_n = 1'b1;
    owner = -1; last = N - 1; stall = 0;
    exp_busy = 0; exp_gid = 0; exp_pulse = 0;
    grants.delete();
    chk_en = 1;
  endtask

  // Monitor: compares every cycle and pops the scoreboard on each handshake.
  always @(negedge comm_clock) begin
    if (chk_en) begin
      chk("busy", busy, exp_busy);
      if (exp_busy) chk("grant_id", grant_id, exp_gid);
      chk("tx_valid", tx_valid, exp_busy && req_valid[exp_gid]);
      chk("req_ready", req_ready, (exp_busy && tx_ready) ? (1 << exp_gid) : 0);
`ifdef USART_ARB_TIMEOUT_EN
      chk("timeout_pulse", timeout_pulse, exp_pulse);
      if (timeout_pulse) begin pulse_cnt++; pulse_cyc = cyc; end
`endif
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          nchecks++; errors++;
          $display("FAIL unexpected_byte: got 0x%02h from %0d expected none", tx_data, grant_id);
        end else begin
          mon_e = exp_q.pop_front();
          chk("byte_cycle", cyc, mon_e.cyc);
          chk("byte_id", grant_id, mon_e.id);
          chk("byte_data", tx_data, mon_e.data);
        end
        if (grant_id == 1) hs1_cyc = cyc;
      end
      if (busy && !prev_busy) grants.push_back(grant_id);
      prev_busy = busy;
    end else begin
      prev_busy = 0;
    end
  end

  initial begin
    #2 do_reset();

    // Single requester, 3-byte packet at full rate.
    load_pkt(2, 3, 0, 8'h41);
    drain();
    chk("t1_grants", grants.size(), 1);
    if (grants.size() > 0) chk("t1_grant2", grants[0], 2);

    // All requesters continuously valid, 1-byte packets: strict rotation.
    @(posedge comm_clock); #1 do_reset();
    for (int r = 0; r < N; r++) begin load_pkt(r, 1, 1, 0); load_pkt(r, 1, 1, 0); end
    drain();
    chk("t2_ngrants", grants.size(), 2 * N);
    for (int k = 0; k < 6; k++)
      if (k < grants.size()) chk("t2_rotation", grants[k], k % N);

    // Requester 1 mid-packet with toggling ready; requester 0 must wait.
    rmode = 2;
    load_pkt(1, 4, 1, 0);
    load_pkt(0, 1, 1, 0);
    mute[0] = 1;
    step(); step();
    mute[0] = 0;
    drain();
    rmode = 0;

    // Reset in the middle of a packet, then requester 0 wins first.
    load_pkt(3, 6, 1, 0);
    step(); step(); step();
    chk("pre_reset_busy", busy, 1);
    do_reset();
    load_pkt(2, 1, 1, 0);
    load_pkt(0, 1, 1, 0);
    drain();
    if (grants.size() > 0) chk("first_after_reset", grants[0], 0);
    else chk("first_after_reset_count", grants.size(), 2);

    // Owner stops sending after one byte.
    load_pkt(1, 2, 0, 8'h11);
    load_pkt(2, 1, 0, 8'h21);
`ifdef USART_ARB_TIMEOUT_EN
    pulse_cnt = 0;
    for (int n = 0; n < 40 && pulse_cnt == 0; n++) begin
      step();
      if (rq[1].size() == 1) mute[1] = 1;
    end
    chk("timeout_seen", pulse_cnt, 1);
    chk("timeout_delay", pulse_cyc - hs1_cyc, T);
    repeat (10) step();
    chk("after_timeout_pulses", pulse_cnt, 1);
    chk("after_timeout_req2_done", rq[2].size(), 0);
`else
    for (int n = 0; n < 200; n++) begin
      step();
      if (rq[1].size() == 1) mute[1] = 1;
    end
    chk("held_busy", busy, 1);
    chk("held_grant", grant_id, 1);
    chk("held_req2_waiting", rq[2].size(), 1);
`endif
    mute[1] = 0;
    drain();

    // Randomized traffic: random gaps and random transmitter back-pressure.
    vmode = 1; rmode = 1;
    for (int r = 0; r < N; r++)
      for (int p = 0; p < 6; p++) load_pkt(r, $urandom_range(1, 4), 1, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, nchecks);
    $finish;
  end

endmodule
